// File: rtl/mux_out_checker_if.sv
// mux_out_checker_if
//   Groups the sample bus and the status outputs of mux_out_checker.
//   master: the producer side (drives samples, reads status).
//   slave : the checker side (reads samples, drives status).
// Signals
//   valid_in, clear                 sample qualifier and soft clear
//   data_conduc_in, data_struc_in   behavioral / structural mux outputs (2 bits)
//   cnt_conduc0/1, cnt_struc0/1     rising-edge counters per bit (CNT_W bits)
//   mismatch, mismatch_count        compare pulse and saturating mismatch count
//   error_sticky, state             sticky error flag and FSM state
interface mux_out_checker_if #(
  parameter int CNT_W = 7
);
  logic             valid_in;
  logic             clear;
  logic [1:0]       data_conduc_in;
  logic [1:0]       data_struc_in;
  logic [CNT_W-1:0] cnt_conduc0;
  logic [CNT_W-1:0] cnt_conduc1;
  logic [CNT_W-1:0] cnt_struc0;
  logic [CNT_W-1:0] cnt_struc1;
  logic             mismatch;
  logic [CNT_W-1:0] mismatch_count;
  logic             error_sticky;
  logic [1:0]       state;

  modport master (
    output valid_in, clear, data_conduc_in, data_struc_in,
    input  cnt_conduc0, cnt_conduc1, cnt_struc0, cnt_struc1,
    input  mismatch, mismatch_count, error_sticky, state
  );

  modport slave (
    input  valid_in, clear, data_conduc_in, data_struc_in,
    output cnt_conduc0, cnt_conduc1, cnt_struc0, cnt_struc1,
    output mismatch, mismatch_count, error_sticky, state
  );
endinterface

// File: rtl/mux_out_checker.sv
// mux_out_checker
//   On-chip checker for the 2-bit registered 2:1 mux. Compares the behavioral
//   and structural outputs on every valid cycle, counts rising edges on each
//   output bit with saturating counters, tracks mismatches and reports a
//   IDLE/RUN/FAIL status.
// Ports
//   clk    rising-edge clock shared with the mux
//   reset  synchronous active-high reset
//   bus    mux_out_checker_if.slave (samples in, counters/status out)
// Parameters
//   CNT_W      width of every counter and of mismatch_count
//   ERR_LIMIT  mismatch_count value that moves the FSM to FAIL (1..2^CNT_W-1)
module mux_out_checker #(
  parameter int CNT_W     = 7,
  parameter int ERR_LIMIT = 1
) (
  input logic               clk,
  input logic               reset,
  mux_out_checker_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_FAIL = 2'b10;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ERR_LIMIT);

  logic [1:0]       state_q;
  logic [1:0]       prev_conduc;
  logic [1:0]       prev_struc;
  logic [CNT_W-1:0] cnt_conduc0_q;
  logic [CNT_W-1:0] cnt_conduc1_q;
  logic [CNT_W-1:0] cnt_struc0_q;
  logic [CNT_W-1:0] cnt_struc1_q;
  logic [CNT_W-1:0] mismatch_count_q;
  logic             mismatch_q;
  logic             error_sticky_q;

  logic             sample_diff;
  logic [1:0]       rise_conduc;
  logic [1:0]       rise_struc;
  logic             count_edges;
  logic [CNT_W-1:0] mismatch_count_next;
  logic             hit_limit;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

  // In IDLE the first valid sample only establishes prev, so edges are
  // counted only once the FSM has left IDLE. The limit test uses the
  // post-increment count so FAIL is entered in the same update that
  // reaches ERR_LIMIT (including straight from IDLE when ERR_LIMIT is 1).
  always_comb begin
    sample_diff         = (bus.data_conduc_in != bus.data_struc_in);
    rise_conduc         = bus.data_conduc_in & ~prev_conduc;
    rise_struc          = bus.data_struc_in & ~prev_struc;
    count_edges         = (state_q != ST_IDLE);
    mismatch_count_next = sat_inc(mismatch_count_q, sample_diff);
    hit_limit           = sample_diff && (mismatch_count_next >= LIMIT);
  end

  // reset and clear are equivalent and both drop any sample presented with
  // them. Without valid_in everything holds except the one-cycle mismatch
  // pulse, which falls back to 0.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      state_q          <= ST_IDLE;
      prev_conduc      <= 2'b00;
      prev_struc       <= 2'b00;
      cnt_conduc0_q    <= '0;
      cnt_conduc1_q    <= '0;
      cnt_struc0_q     <= '0;
      cnt_struc1_q     <= '0;
      mismatch_count_q <= '0;
      mismatch_q       <= 1'b0;
      error_sticky_q   <= 1'b0;
    end else if (bus.valid_in) begin
      mismatch_q       <= sample_diff;
      mismatch_count_q <= mismatch_count_next;
      error_sticky_q   <= error_sticky_q | sample_diff;
      prev_conduc      <= bus.data_conduc_in;
      prev_struc       <= bus.data_struc_in;
      cnt_conduc0_q    <= sat_inc(cnt_conduc0_q, count_edges & rise_conduc[0]);
      cnt_conduc1_q    <= sat_inc(cnt_conduc1_q, count_edges & rise_conduc[1]);
      cnt_struc0_q     <= sat_inc(cnt_struc0_q, count_edges & rise_struc[0]);
      cnt_struc1_q     <= sat_inc(cnt_struc1_q, count_edges & rise_struc[1]);
      if (state_q == ST_FAIL) begin
        state_q <= ST_FAIL;
      end else if (hit_limit) begin
        state_q <= ST_FAIL;
      end else begin
        state_q <= ST_RUN;
      end
    end else begin
      mismatch_q <= 1'b0;
    end
  end

  assign bus.cnt_conduc0    = cnt_conduc0_q;
  assign bus.cnt_conduc1    = cnt_conduc1_q;
  assign bus.cnt_struc0     = cnt_struc0_q;
  assign bus.cnt_struc1     = cnt_struc1_q;
  assign bus.mismatch       = mismatch_q;
  assign bus.mismatch_count = mismatch_count_q;
  assign bus.error_sticky   = error_sticky_q;
  assign bus.state          = state_q;

endmodule

// File: tb/tb_mux_out_checker.sv
// tb_mux_out_checker
//   Drives three checker instances in lockstep with the same samples:
//   dut_a (CNT_W=7, ERR_LIMIT=1), dut_b (CNT_W=3, ERR_LIMIT=1) and
//   dut_c (CNT_W=7, ERR_LIMIT=3), and compares each against a behavioural
//   model built from integer counts and simple flags.
module tb_mux_out_checker;

  logic clk_probador = 1'b0;
  logic reset;

  always #5 clk_probador = ~clk_probador;

  mux_out_checker_if #(.CNT_W(7)) bus_a ();
  mux_out_checker_if #(.CNT_W(3)) bus_b ();
  mux_out_checker_if #(.CNT_W(7)) bus_c ();

  mux_out_checker #(.CNT_W(7), .ERR_LIMIT(1)) dut_a (
    .clk(clk_probador), .reset(reset), .bus(bus_a));
  mux_out_checker #(.CNT_W(3), .ERR_LIMIT(1)) dut_b (
    .clk(clk_probador), .reset(reset), .bus(bus_b));
  mux_out_checker #(.CNT_W(7), .ERR_LIMIT(3)) dut_c (
    .clk(clk_probador), .reset(reset), .bus(bus_c));

  typedef struct packed {
    logic [6:0] cc0;
    logic [6:0] cc1;
    logic [6:0] cs0;
    logic [6:0] cs1;
    logic       mism;
    logic [6:0] mcnt;
    logic       err;
    logic [1:0] st;
  } obs_t;

  int vectors = 0;
  int miscompares = 0;

  int max_val [3] = '{127, 7, 127};
  int lim_val [3] = '{1, 1, 3};

  int       m_cc0 [3];
  int       m_cc1 [3];
  int       m_cs0 [3];
  int       m_cs1 [3];
  int       m_mcnt [3];
  bit       m_mism [3];
  bit       m_err [3];
  bit       m_started [3];
  bit       m_failed [3];
  bit [1:0] m_pc [3];
  bit [1:0] m_ps [3];

  function automatic int sat_add(input int v, input int mx);
    return (v < mx) ? v + 1 : mx;
  endfunction

  // Reference behaviour: counts are plain integers clipped at the maximum,
  // "started" marks that a baseline sample has been seen since the last
  // reset/clear, and "failed" latches once enough mismatches have arrived.
  task automatic model_step(input bit rst, input bit clr, input bit v,
                            input bit [1:0] c, input bit [1:0] s);
    for (int k = 0; k < 3; k++) begin
      if (rst || clr) begin
        m_cc0[k] = 0; m_cc1[k] = 0; m_cs0[k] = 0; m_cs1[k] = 0;
        m_mcnt[k] = 0; m_mism[k] = 0; m_err[k] = 0;
        m_started[k] = 0; m_failed[k] = 0; m_pc[k] = 0; m_ps[k] = 0;
      end else if (v) begin
        m_mism[k] = (c != s);
        if (c != s) begin
          m_mcnt[k] = sat_add(m_mcnt[k], max_val[k]);
          m_err[k] = 1;
          if (m_mcnt[k] >= lim_val[k]) m_failed[k] = 1;
        end
        if (m_started[k]) begin
          if (!m_pc[k][0] && c[0]) m_cc0[k] = sat_add(m_cc0[k], max_val[k]);
          if (!m_pc[k][1] && c[1]) m_cc1[k] = sat_add(m_cc1[k], max_val[k]);
          if (!m_ps[k][0] && s[0]) m_cs0[k] = sat_add(m_cs0[k], max_val[k]);
          if (!m_ps[k][1] && s[1]) m_cs1[k] = sat_add(m_cs1[k], max_val[k]);
        end
        m_pc[k] = c;
        m_ps[k] = s;
        m_started[k] = 1;
      end else begin
        m_mism[k] = 0;
      end
    end
  endtask

  function automatic obs_t expected(input int k);
    obs_t o;
    o.cc0  = 7'(m_cc0[k]);
    o.cc1  = 7'(m_cc1[k]);
    o.cs0  = 7'(m_cs0[k]);
    o.cs1  = 7'(m_cs1[k]);
    o.mism = m_mism[k];
    o.mcnt = 7'(m_mcnt[k]);
    o.err  = m_err[k];
    o.st   = m_failed[k] ? 2'b10 : (m_started[k] ? 2'b01 : 2'b00);
    return o;
  endfunction

  function automatic obs_t observed(input int k);
    obs_t o;
    if (k == 0) begin
      o = {bus_a.cnt_conduc0, bus_a.cnt_conduc1, bus_a.cnt_struc0, bus_a.cnt_struc1,
           bus_a.mismatch, bus_a.mismatch_count, bus_a.error_sticky, bus_a.state};
    end else if (k == 1) begin
      o = {4'b0, bus_b.cnt_conduc0, 4'b0, bus_b.cnt_conduc1,
           4'b0, bus_b.cnt_struc0, 4'b0, bus_b.cnt_struc1,
           bus_b.mismatch, 4'b0, bus_b.mismatch_count, bus_b.error_sticky, bus_b.state};
    end else begin
      o = {bus_c.cnt_conduc0, bus_c.cnt_conduc1, bus_c.cnt_struc0, bus_c.cnt_struc1,
           bus_c.mismatch, bus_c.mismatch_count, bus_c.error_sticky, bus_c.state};
    end
    return o;
  endfunction

  // One clock: drive all three buses, let the edge happen, advance the
  // model, then settle #1 so outputs are sampled away from the edge.
  task automatic applyStimulus(input bit rst, input bit clr, input bit v,
                               input bit [1:0] c, input bit [1:0] s);
    reset = rst;
    bus_a.clear = clr; bus_a.valid_in = v; bus_a.data_conduc_in = c; bus_a.data_struc_in = s;
    bus_b.clear = clr; bus_b.valid_in = v; bus_b.data_conduc_in = c; bus_b.data_struc_in = s;
    bus_c.clear = clr; bus_c.valid_in = v; bus_c.data_conduc_in = c; bus_c.data_struc_in = s;
    @(posedge clk_probador);
    model_step(rst, clr, v, c, s);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (observed(k) !== expected(k)) begin
          miscompares++;
          $display("[TB] FAIL reset dut%0d got %h want %h", k, observed(k), expected(k));
        end
      end
    end
  endtask

  task automatic test_equal_sequence();
    bit [1:0] seq [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b11};
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    foreach (seq[i]) begin
      applyStimulus(1'b0, 1'b0, 1'b1, seq[i], seq[i]);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (observed(k) !== expected(k)) begin
          miscompares++;
          $display("[TB] FAIL equal_seq[%0d] dut%0d got %h want %h", i, k, observed(k), expected(k));
        end
      end
    end
    vectors++;
    if ({bus_a.cnt_conduc0, bus_a.cnt_conduc1, bus_a.cnt_struc0, bus_a.cnt_struc1, bus_a.state}
        !== {7'd2, 7'd1, 7'd2, 7'd1, 2'b01}) begin
      miscompares++;
      $display("[TB] FAIL equal_seq_final got c0=%0d c1=%0d s0=%0d s1=%0d st=%0d want 2 1 2 1 1",
               bus_a.cnt_conduc0, bus_a.cnt_conduc1, bus_a.cnt_struc0, bus_a.cnt_struc1, bus_a.state);
    end
  endtask

  task automatic test_baseline();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 2'b11);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (observed(k) !== expected(k)) begin
        miscompares++;
        $display("[TB] FAIL baseline dut%0d got %h want %h", k, observed(k), expected(k));
      end
    end
    vectors++;
    if ({bus_a.cnt_conduc0, bus_a.cnt_conduc1, bus_a.state} !== {7'd0, 7'd0, 2'b01}) begin
      miscompares++;
      $display("[TB] FAIL baseline_counts got c0=%0d c1=%0d st=%0d want 0 0 1",
               bus_a.cnt_conduc0, bus_a.cnt_conduc1, bus_a.state);
    end
  endtask

  task automatic test_single_mismatch();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 2'b00);
    vectors++;
    if ({bus_a.mismatch, bus_a.mismatch_count, bus_a.error_sticky, bus_a.state}
        !== {1'b1, 7'd1, 1'b1, 2'b10}) begin
      miscompares++;
      $display("[TB] FAIL single_mismatch got m=%0b cnt=%0d err=%0b st=%0d want 1 1 1 2",
               bus_a.mismatch, bus_a.mismatch_count, bus_a.error_sticky, bus_a.state);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b11, 2'b00);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (observed(k) !== expected(k)) begin
        miscompares++;
        $display("[TB] FAIL mismatch_pulse dut%0d got %h want %h", k, observed(k), expected(k));
      end
    end
  endtask

  task automatic test_clear();
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 2'b01);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (observed(k) !== expected(k)) begin
        miscompares++;
        $display("[TB] FAIL clear dut%0d got %h want %h", k, observed(k), expected(k));
      end
    end
    vectors++;
    if ({bus_a.mismatch_count, bus_a.error_sticky, bus_a.state} !== {7'd0, 1'b0, 2'b00}) begin
      miscompares++;
      $display("[TB] FAIL clear_status got cnt=%0d err=%0b st=%0d want 0 0 0",
               bus_a.mismatch_count, bus_a.error_sticky, bus_a.state);
    end
  endtask

  task automatic test_saturation();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, (i % 2 == 1) ? 2'b01 : 2'b00, (i % 2 == 1) ? 2'b01 : 2'b00);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (observed(k) !== expected(k)) begin
          miscompares++;
          $display("[TB] FAIL saturation[%0d] dut%0d got %h want %h", i, k, observed(k), expected(k));
        end
      end
    end
    vectors++;
    if (bus_b.cnt_conduc0 !== 3'd7) begin
      miscompares++;
      $display("[TB] FAIL saturation_cnt3 got %0d want 7", bus_b.cnt_conduc0);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (observed(k) !== expected(k)) begin
          miscompares++;
          $display("[TB] FAIL hold[%0d] dut%0d got %h want %h", i, k, observed(k), expected(k));
        end
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b11, 2'b11);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (observed(k) !== expected(k)) begin
        miscompares++;
        $display("[TB] FAIL hold_resume dut%0d got %h want %h", k, observed(k), expected(k));
      end
    end
  endtask

  task automatic test_err_limit();
    bit [1:0] want_st [3] = '{2'b01, 2'b01, 2'b10};
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b10, 2'b00);
      vectors++;
      if (bus_c.state !== want_st[i]) begin
        miscompares++;
        $display("[TB] FAIL err_limit3 mismatch#%0d got state %0d want %0d", i + 1, bus_c.state, want_st[i]);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 2'b01);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (observed(k) !== expected(k)) begin
          miscompares++;
          $display("[TB] FAIL err_limit[%0d] dut%0d got %h want %h", i, k, observed(k), expected(k));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 2'(i), 2'(i + 1));
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (observed(k) !== expected(k)) begin
          miscompares++;
          $display("[TB] FAIL back_to_back[%0d] dut%0d got %h want %h", i, k, observed(k), expected(k));
        end
      end
    end
  endtask

  task automatic test_random();
    bit       v;
    bit       clr;
    bit [1:0] c;
    bit [1:0] s;
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 39) == 0);
      c   = 2'($urandom_range(0, 3));
      s   = ($urandom_range(0, 9) < 8) ? c : 2'($urandom_range(0, 3));
      applyStimulus(1'b0, clr, v, c, s);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (observed(k) !== expected(k)) begin
          miscompares++;
          $display("[TB] FAIL random[%0d] dut%0d got %h want %h", i, k, observed(k), expected(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal_sequence();
    test_baseline();
    test_single_mismatch();
    test_clear();
    test_saturation();
    test_hold();
    test_err_limit();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
